// File: rtl/fetch_queue.sv
// fetch_queue: PC register feeding a DEPTH-entry {PC, instruction} FIFO toward decode, with branch flush
module fetch_queue #(
  parameter int unsigned N = 64,
  parameter int unsigned DEPTH = 4,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int unsigned INC = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PCSrc_F,
  input  logic [N-1:0]                 PCBranch_F,
  output logic [N-1:0]                 imem_addr_F,
  input  logic [31:0]                  imem_data_F,
  output logic                         instr_valid_D,
  input  logic                         instr_ready_D,
  output logic [31:0]                  instr_D,
  output logic [N-1:0]                 pc_D,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_F
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH+1);
  logic [N-1:0] pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [N-1:0] pc_mem_q [DEPTH];
  logic [31:0] ins_mem_q [DEPTH];
  logic deq, full, enq;
  assign imem_addr_F = pc_q;
  assign instr_valid_D = occ_q != '0;
  assign instr_D = ins_mem_q[head_q];
  assign pc_D = pc_mem_q[head_q];
  assign occupancy_F = occ_q;
  // Redirect flushes everything and suppresses the enqueue; otherwise fetch whenever a slot is free or freeing
  always_comb begin
    deq = instr_valid_D && instr_ready_D;
    full = occ_q == OW'(DEPTH);
    enq = !PCSrc_F && (!full || deq);
    pc_d = PCSrc_F ? PCBranch_F : enq ? pc_q + N'(INC) : pc_q;
    head_d = PCSrc_F ? '0 : deq ? head_q + AW'(1) : head_q;
    tail_d = PCSrc_F ? '0 : enq ? tail_q + AW'(1) : tail_q;
    occ_d = PCSrc_F ? '0 : occ_q + OW'(enq) - OW'(deq);
  end
  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      head_q <= '0;
      tail_q <= '0;
      occ_q <= '0;
    end else begin
      pc_q <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q <= occ_d;
    end
  end
  // Entry storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      pc_mem_q[tail_q] <= pc_q;
      ins_mem_q[tail_q] <= imem_data_F;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue
module tb_fetch_queue;
  localparam logic [63:0] RPC2 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] TGT = 64'hAAAA_BBBB_CCCC_DDDC;
  logic clk = 0;
  logic reset, pcsrc, ready;
  logic [63:0] branch, addr, pc_d;
  logic [31:0] idata, instr;
  logic valid;
  logic [2:0] occ;
  logic reset2, pcsrc2, ready2;
  logic [63:0] branch2, addr2, pc_d2;
  logic [31:0] idata2, instr2;
  logic valid2;
  logic [2:0] occ2;
  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] sb [$];
  always #5 clk = ~clk;
  assign idata = addr[31:0] + 32'h1000_0000;
  assign idata2 = addr2[31:0] + 32'h1000_0000;
  fetch_queue #(.N(64), .DEPTH(4), .RESET_PC(64'h0), .INC(4)) dut (
    .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(branch),
    .imem_addr_F(addr), .imem_data_F(idata), .instr_valid_D(valid),
    .instr_ready_D(ready), .instr_D(instr), .pc_D(pc_d), .occupancy_F(occ)
  );
  fetch_queue #(.N(64), .DEPTH(4), .RESET_PC(RPC2), .INC(4)) dut2 (
    .clk(clk), .reset(reset2), .PCSrc_F(pcsrc2), .PCBranch_F(branch2),
    .imem_addr_F(addr2), .imem_data_F(idata2), .instr_valid_D(valid2),
    .instr_ready_D(ready2), .instr_D(instr2), .pc_D(pc_d2), .occupancy_F(occ2)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    logic [63:0] e;
    if (!reset && !pcsrc && valid && ready && sb.size() != 0) begin
      e = sb.pop_front();
      check("pc_D", pc_d, e);
      check("instr_D", {32'b0, instr}, {32'b0, e[31:0] + 32'h1000_0000});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic push_seq(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back(base + 64'(4 * i));
  endtask
  initial begin
    reset = 1; pcsrc = 0; ready = 1; branch = '0;
    reset2 = 1; pcsrc2 = 0; ready2 = 1; branch2 = '0;
    for (int i = 0; i < 5; i++) cycle();
    check("rst_addr", addr, 64'h0);
    check("rst_valid", {63'b0, valid}, 64'h0);
    check("rst_occ", {61'b0, occ}, 64'h0);
    check("rst2_addr", addr2, RPC2);
    reset = 0; reset2 = 0;
    push_seq(64'h0, 5);
    cycle();
    check("first_valid", {63'b0, valid}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      check("stream_occ", {61'b0, occ}, 64'h1);
      if (i < 4) check("wrap_pc_D", pc_d2, RPC2 + 64'(4 * i));
      cycle();
    end
    check("sb_empty_1", 64'(sb.size()), 64'h0);
    reset = 1; ready = 0;
    cycle();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("fill_occ", {61'b0, occ}, 64'(i < 4 ? i + 1 : 4));
    end
    check("stall_addr", addr, 64'h10);
    push_seq(64'h0, 6);
    ready = 1;
    for (int i = 0; i < 6; i++) cycle();
    check("sb_empty_2", 64'(sb.size()), 64'h0);
    check("full_stream_occ", {61'b0, occ}, 64'h4);
    pcsrc = 1; branch = TGT;
    cycle();
    pcsrc = 0;
    check("redir_addr", addr, TGT);
    check("redir_valid", {63'b0, valid}, 64'h0);
    check("redir_occ", {61'b0, occ}, 64'h0);
    push_seq(TGT, 2);
    cycle();
    check("redir_first", pc_d, TGT);
    for (int i = 0; i < 2; i++) cycle();
    check("sb_empty_3", 64'(sb.size()), 64'h0);
    reset = 1; ready = 0;
    cycle();
    reset = 0;
    for (int i = 0; i < 5; i++) cycle();
    check("full_occ", {61'b0, occ}, 64'h4);
    check("full_head", pc_d, 64'h0);
    ready = 1; pcsrc = 1; branch = 64'h2000;
    cycle();
    pcsrc = 0;
    check("flush_occ", {61'b0, occ}, 64'h0);
    check("flush_valid", {63'b0, valid}, 64'h0);
    check("flush_addr", addr, 64'h2000);
    push_seq(64'h2000, 3);
    for (int i = 0; i < 4; i++) cycle();
    check("sb_empty_4", 64'(sb.size()), 64'h0);
    ready = 0;
    for (int i = 0; i < 4; i++) cycle();
    check("prerst_occ", {61'b0, occ}, 64'h4);
    reset = 1;
    cycle();
    check("mid_rst_valid", {63'b0, valid}, 64'h0);
    check("mid_rst_occ", {61'b0, occ}, 64'h0);
    check("mid_rst_addr", addr, 64'h0);
    reset = 0; ready = 1;
    push_seq(64'h0, 3);
    cycle();
    check("post_rst_head", pc_d, 64'h0);
    for (int i = 0; i < 3; i++) cycle();
    check("sb_empty_6", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
